mem_stage_sram_ctrl: RTL and testbench

MEM_STAGE_SRAM_CTRL -- requirements
Module: mem_stage_sram_ctrl

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_stage_sram_ctrl_if.sv | 27 ++
 rtl/sram_word_cache.sv | 37 +++
 rtl/mem_stage_sram_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller: FSM states,
// default data base address, SRAM bus widths and word-address helper.
package mem_stage_pkg;

  localparam int unsigned DATA_BASE_DEF = 1024;
  localparam int unsigned SRAM_AW       = 18;
  localparam int unsigned SRAM_DW       = 16;
  localparam int unsigned WORD_AW       = 17;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_e;

  // Word index relative to the data segment; wraps modulo 2^WORD_AW.
  function automatic logic [WORD_AW-1:0] word_of(input logic [31:0] addr,
                                                 input logic [31:0] base);
    return WORD_AW'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// 16-bit asynchronous SRAM bus; master is the controller, slave the SRAM.
interface mem_stage_sram_ctrl_if;
  import mem_stage_pkg::*;

  logic [SRAM_AW-1:0] sram_addr;
  logic [SRAM_DW-1:0] sram_dq_o;
  logic [SRAM_DW-1:0] sram_dq_i;
  logic               sram_dq_oe;
  logic               sram_we_n;

  modport master (
    output sram_addr,
    output sram_dq_o,
    output sram_dq_oe,
    output sram_we_n,
    input  sram_dq_i
  );

  modport slave (
    input  sram_addr,
    input  sram_dq_o,
    input  sram_dq_oe,
    input  sram_we_n,
    output sram_dq_i
  );

endinterface

// File: rtl/sram_word_cache.sv
// One-entry word cache (valid, tag, data) for the MEM-stage SRAM controller.
// Compiled only when MEM_SRAM_WORD_CACHE_EN is defined.
`ifdef MEM_SRAM_WORD_CACHE_EN
module sram_word_cache
  import mem_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_AW-1:0] lookup_tag,
  input  logic               fill,
  input  logic [WORD_AW-1:0] fill_tag,
  input  logic [31:0]        fill_data,
  output logic               hit,
  output logic [31:0]        data
);

  logic               valid;
  logic [WORD_AW-1:0] tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end
  end

  always_comb begin
    hit = valid && (tag == lookup_tag);
  end

endmodule
`endif

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller splitting each 32-bit access into two 16-bit SRAM phases.
// Optional one-entry read cache: define MEM_SRAM_WORD_CACHE_EN.
module mem_stage_sram_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 1,
  parameter int unsigned DATA_BASE = DATA_BASE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [31:0]           addr_in,
  input  logic [31:0]           wdata_in,
  output logic [31:0]           rdata_out,
  output logic                  ready_out,
  output logic                  freeze_out,
  mem_stage_sram_ctrl_if.master sram
);

  localparam logic [3:0]  WAIT_M1 = 4'(SRAM_WAIT - 1);
  localparam logic [31:0] BASE    = 32'(DATA_BASE);

  state_e             state, state_nx;
  logic [3:0]         cnt;
  logic [WORD_AW-1:0] word_in, word_q;
  logic [31:0]        wdata_q, rdata_q;
  logic               wr_q;
  logic               req, launch, phase_end;
  logic               hit;
  logic [31:0]        cache_data;

  always_comb begin
    word_in = word_of(addr_in, BASE);
  end

`ifdef MEM_SRAM_WORD_CACHE_EN
  logic cache_hit;

  sram_word_cache u_cache (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (word_in),
    .fill       (state == DONE),
    .fill_tag   (word_q),
    .fill_data  (wr_q ? wdata_q : rdata_q),
    .hit        (cache_hit),
    .data       (cache_data)
  );

  // Only a pure read in IDLE may be served from the cache; writes always go through.
  always_comb begin
    hit = cache_hit && mem_read_in && !mem_write_in && (state == IDLE);
  end
`else
  always_comb begin
    hit        = 1'b0;
    cache_data = '0;
  end
`endif

  always_comb begin
    req       = mem_read_in | mem_write_in;
    launch    = (state == IDLE) && req && !hit;
    phase_end = (cnt == WAIT_M1);
    state_nx  = state;
    ready_out = 1'b0;
    case (state)
      IDLE: begin
        ready_out = ~req | hit;
        if (launch) state_nx = LO;
      end
      LO:   if (phase_end) state_nx = HI;
      HI:   if (phase_end) state_nx = DONE;
      DONE: begin
        ready_out = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    freeze_out = req & ~ready_out;
    rdata_out  = hit ? cache_data : rdata_q;
  end

  // SRAM outputs are registered one phase ahead so they are stable for every
  // cycle of LO/HI and simply hold their last value elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      word_q          <= '0;
      wdata_q         <= '0;
      wr_q            <= 1'b0;
      rdata_q         <= '0;
      sram.sram_addr  <= '0;
      sram.sram_dq_o  <= '0;
      sram.sram_dq_oe <= 1'b0;
      sram.sram_we_n  <= 1'b1;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (launch) begin
            word_q          <= word_in;
            wdata_q         <= wdata_in;
            wr_q            <= mem_write_in;
            cnt             <= '0;
            sram.sram_addr  <= {word_in, 1'b0};
            sram.sram_dq_o  <= wdata_in[15:0];
            sram.sram_dq_oe <= mem_write_in;
            sram.sram_we_n  <= ~mem_write_in;
          end
        end
        LO: begin
          if (phase_end) begin
            cnt            <= '0;
            sram.sram_addr <= {word_q, 1'b1};
            sram.sram_dq_o <= wdata_q[31:16];
            if (!wr_q) rdata_q[15:0] <= sram.sram_dq_i;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HI: begin
          if (phase_end) begin
            cnt             <= '0;
            sram.sram_dq_oe <= 1'b0;
            sram.sram_we_n  <= 1'b1;
            if (!wr_q) rdata_q[31:16] <= sram.sram_dq_i;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed self-checking bench for mem_stage_sram_ctrl (SRAM_WAIT=1 and 3).
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        rd_a = 1'b0, wr_a = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0, rdata_a;
  logic        ready_a, freeze_a;

  logic        rd_b = 1'b0, wr_b = 1'b0;
  logic [31:0] addr_b = '0, wdata_b = '0, rdata_b;
  logic        ready_b, freeze_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] mem_a [0:4095];
  logic [15:0] mem_b [0:4095];

  mem_stage_sram_ctrl_if bus_a ();
  mem_stage_sram_ctrl_if bus_b ();

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.SRAM_WAIT(1), .DATA_BASE(1024)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .mem_read_in  (rd_a),
    .mem_write_in (wr_a),
    .addr_in      (addr_a),
    .wdata_in     (wdata_a),
    .rdata_out    (rdata_a),
    .ready_out    (ready_a),
    .freeze_out   (freeze_a),
    .sram         (bus_a)
  );

  mem_stage_sram_ctrl #(.SRAM_WAIT(3), .DATA_BASE(1024)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .mem_read_in  (rd_b),
    .mem_write_in (wr_b),
    .addr_in      (addr_b),
    .wdata_in     (wdata_b),
    .rdata_out    (rdata_b),
    .ready_out    (ready_b),
    .freeze_out   (freeze_b),
    .sram         (bus_b)
  );

  // Simple SRAM models: combinational read, write on clock edge while strobed.
  assign bus_a.sram_dq_i = mem_a[bus_a.sram_addr[11:0]];
  assign bus_b.sram_dq_i = mem_b[bus_b.sram_addr[11:0]];

  always @(posedge clk) begin
    if (bus_a.sram_dq_oe && !bus_a.sram_we_n)
      mem_a[bus_a.sram_addr[11:0]] <= bus_a.sram_dq_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    mem_b[2] = 16'h1111;
    mem_b[3] = 16'h2222;

    // Reset values
    cyc();
    cyc();
    check("rst_ready",  ready_a, 1);
    check("rst_freeze", freeze_a, 0);
    check("rst_rdata",  rdata_a, 0);
    check("rst_addr",   bus_a.sram_addr, 0);
    check("rst_dq_o",   bus_a.sram_dq_o, 0);
    check("rst_oe",     bus_a.sram_dq_oe, 0);
    check("rst_we_n",   bus_a.sram_we_n, 1);
    rst = 1'b0;

    // Write 0xDEADBEEF to byte 1028 (word 1 -> half-words 2,3)
    cyc();
    wr_a = 1; addr_a = 1028; wdata_a = 32'hDEADBEEF; #1;
    check("wr_c0_ready",  ready_a, 0);
    check("wr_c0_freeze", freeze_a, 1);
    check("wr_c0_we_n",   bus_a.sram_we_n, 1);
    cyc();
    check("wr_c1_addr",   bus_a.sram_addr, 2);
    check("wr_c1_dq",     bus_a.sram_dq_o, 16'hBEEF);
    check("wr_c1_we_n",   bus_a.sram_we_n, 0);
    check("wr_c1_oe",     bus_a.sram_dq_oe, 1);
    check("wr_c1_ready",  ready_a, 0);
    cyc();
    check("wr_c2_addr",   bus_a.sram_addr, 3);
    check("wr_c2_dq",     bus_a.sram_dq_o, 16'hDEAD);
    check("wr_c2_we_n",   bus_a.sram_we_n, 0);
    check("wr_c2_freeze", freeze_a, 1);
    cyc();
    check("wr_c3_ready",  ready_a, 1);
    check("wr_c3_freeze", freeze_a, 0);
    check("wr_c3_we_n",   bus_a.sram_we_n, 1);
    check("wr_c3_oe",     bus_a.sram_dq_oe, 0);
    check("wr_c3_addr",   bus_a.sram_addr, 3);
    wr_a = 0;
    cyc();
    check("wr_idle_ready", ready_a, 1);
    check("wr_idle_we_n",  bus_a.sram_we_n, 1);

    // Read back 1028
    rd_a = 1; addr_a = 1028; #1;
    check("rd_c0_ready",  ready_a, 0);
    check("rd_c0_freeze", freeze_a, 1);
    cyc();
    check("rd_c1_addr",   bus_a.sram_addr, 2);
    check("rd_c1_we_n",   bus_a.sram_we_n, 1);
    check("rd_c1_oe",     bus_a.sram_dq_oe, 0);
    check("rd_c1_freeze", freeze_a, 1);
    cyc();
    check("rd_c2_addr",   bus_a.sram_addr, 3);
    check("rd_c2_freeze", freeze_a, 1);
    cyc();
    check("rd_c3_ready",  ready_a, 1);
    check("rd_c3_freeze", freeze_a, 0);
    check("rd_c3_rdata",  rdata_a, 32'hDEADBEEF);
    rd_a = 0;

    // Inputs changing mid-access are ignored
    cyc();
    wr_a = 1; addr_a = 1032; wdata_a = 32'h12345678; #1;
    cyc();
    wr_a = 0; rd_a = 1; addr_a = 2000; wdata_a = 0; #1;
    check("lat_c1_addr", bus_a.sram_addr, 4);
    check("lat_c1_dq",   bus_a.sram_dq_o, 16'h5678);
    cyc();
    check("lat_c2_addr", bus_a.sram_addr, 5);
    check("lat_c2_dq",   bus_a.sram_dq_o, 16'h1234);
    check("lat_c2_we_n", bus_a.sram_we_n, 0);
    cyc();
    check("lat_c3_ready", ready_a, 1);
    rd_a = 0;
    cyc();
    rd_a = 1; addr_a = 1032; #1;
    cyc(); cyc(); cyc();
    check("lat_rd_ready", ready_a, 1);
    check("lat_rd_rdata", rdata_a, 32'h12345678);
    rd_a = 0;

    // Address below DATA_BASE wraps modulo 2^17 words
    cyc();
    rd_a = 1; addr_a = 1020; #1;
    cyc();
    check("wrap_lo_addr", bus_a.sram_addr, 18'h3FFFE);
    cyc();
    check("wrap_hi_addr", bus_a.sram_addr, 18'h3FFFF);
    cyc();
    check("wrap_ready", ready_a, 1);
    rd_a = 0;

    // Both requests: write wins; reset during HI aborts
    cyc();
    rd_a = 1; wr_a = 1; addr_a = 1036; wdata_a = 32'hCAFEF00D; #1;
    cyc();
    check("both_c1_we_n", bus_a.sram_we_n, 0);
    check("both_c1_oe",   bus_a.sram_dq_oe, 1);
    check("both_c1_addr", bus_a.sram_addr, 6);
    check("both_c1_dq",   bus_a.sram_dq_o, 16'hF00D);
    cyc();
    check("both_c2_addr", bus_a.sram_addr, 7);
    rst = 1; rd_a = 0; wr_a = 0;
    cyc();
    check("abort_we_n",  bus_a.sram_we_n, 1);
    check("abort_oe",    bus_a.sram_dq_oe, 0);
    check("abort_ready", ready_a, 1);
    check("abort_addr",  bus_a.sram_addr, 0);
    check("abort_rdata", rdata_a, 0);
    rst = 0;
    cyc();
    check("abort_idle_we_n", bus_a.sram_we_n, 1);
    check("abort_idle_oe",   bus_a.sram_dq_oe, 0);

    // Write 1040 then read 1040, then read 1044
    wr_a = 1; addr_a = 1040; wdata_a = 32'hA5A55A5A; #1;
    cyc(); cyc(); cyc();
    check("c_wr_ready", ready_a, 1);
    wr_a = 0;
    cyc();
    rd_a = 1; addr_a = 1040; #1;
`ifdef MEM_SRAM_WORD_CACHE_EN
    check("c_hit_ready", ready_a, 1);
    check("c_hit_rdata", rdata_a, 32'hA5A55A5A);
    check("c_hit_we_n",  bus_a.sram_we_n, 1);
    check("c_hit_addr",  bus_a.sram_addr, 9);
    addr_a = 1044; #1;
    check("c_miss_c0_ready", ready_a, 0);
    cyc();
    check("c_miss_c1_addr", bus_a.sram_addr, 10);
    cyc(); cyc();
    check("c_miss_c3_ready", ready_a, 1);
`else
    check("nc_c0_ready", ready_a, 0);
    cyc();
    check("nc_c1_addr",  bus_a.sram_addr, 8);
    check("nc_c1_ready", ready_a, 0);
    cyc(); cyc();
    check("nc_c3_ready", ready_a, 1);
    check("nc_c3_rdata", rdata_a, 32'hA5A55A5A);
`endif
    rd_a = 0;

    // SRAM_WAIT=3 read: each half-word held 3 cycles, ready at cycle 7
    cyc();
    rd_b = 1; addr_b = 1028; #1;
    check("w3_c0_ready", ready_b, 0);
    begin
      int unsigned k;
      bit done_seen;
      done_seen = 0;
      for (k = 1; k <= 20 && !done_seen; k++) begin
        cyc();
        if (ready_b) begin
          done_seen = 1;
          check("w3_ready_cycle", k, 7);
          check("w3_rdata", rdata_b, 32'h22221111);
        end else if (k <= 3) begin
          check("w3_lo_addr", bus_b.sram_addr, 2);
        end else begin
          check("w3_hi_addr", bus_b.sram_addr, 3);
        end
      end
      if (!done_seen) check("w3_timeout", 0, 1);
    end
    rd_b = 0;
    cyc();
    check("w3_idle_ready", ready_b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
